// File: rtl/bus_downlink_tx.sv
// bus_downlink_tx
//   Queues {id,data} entries from a host and sends them one at a time on a
//   shared downlink bus. Each transaction stays on the bus until the
//   addressed device acknowledges it, or until TIMEOUT bus_valid cycles pass.
//   A timed-out entry is dropped and reported through err/err_id.
//
// Ports
//   clk, reset        : clock; asynchronous active-low reset
//   in_valid/in_ready : host push handshake; in_id/in_data carry the entry
//   bus_valid/bus_id/bus_data : current downlink transaction
//   bus_ack/bus_ack_id: shared acknowledge wire and the id of the responder
//   err/err_id        : one-cycle timeout pulse; id of the dropped entry
//   sent_count        : wrapping count of acknowledged transactions
module bus_downlink_tx #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_id,
  input  logic [31:0] in_data,
  output logic        bus_valid,
  output logic [3:0]  bus_id,
  output logic [31:0] bus_data,
  input  logic        bus_ack,
  input  logic [3:0]  bus_ack_id,
  output logic        err,
  output logic [3:0]  err_id,
  output logic [7:0]  sent_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {ST_IDLE, ST_SEND} state_t;

  state_t             r_state;
  state_t             w_state_next;

  logic [35:0]        r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  logic               r_bus_valid;
  logic [3:0]         r_bus_id;
  logic [31:0]        r_bus_data;
  logic [7:0]         r_timer;
  logic               r_err;
  logic [3:0]         r_err_id;
  logic [7:0]         r_sent_count;

  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_match;
  logic               w_load;
  logic               w_pop;
  logic               w_ack_done;
  logic               w_timeout;
  logic [35:0]        w_head;

  assign w_full   = (r_count == CNT_W'(DEPTH));
  assign w_empty  = (r_count == '0);
  // Gated by reset so the host sees "not ready" for the whole reset window.
  assign in_ready = reset & ~w_full;
  assign w_push   = in_valid & in_ready;
  assign w_match  = bus_ack && (bus_ack_id == r_bus_id);
  assign w_head   = r_mem[r_rd_ptr];

  // Entry storage: written only, never reset; validity comes from r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {in_id, in_data};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // The head stays in the queue while on the bus; it is popped only when the
  // transaction finishes (ack or timeout). An ack landing on the timeout edge
  // wins over the timeout.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_pop        = 1'b0;
    w_ack_done   = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_load       = 1'b1;
          w_state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        if (w_match) begin
          w_pop        = 1'b1;
          w_ack_done   = 1'b1;
          w_state_next = ST_IDLE;
        end else if (r_timer == 8'(TIMEOUT - 1)) begin
          w_pop        = 1'b1;
          w_timeout    = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_bus_valid  <= 1'b0;
      r_bus_id     <= '0;
      r_bus_data   <= '0;
      r_timer      <= '0;
      r_err        <= 1'b0;
      r_err_id     <= '0;
      r_sent_count <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      // Returning to IDLE on every pop guarantees an idle bus cycle between
      // consecutive transactions.
      if (w_load) begin
        r_bus_valid <= 1'b1;
        r_bus_id    <= w_head[35:32];
        r_bus_data  <= w_head[31:0];
      end else if (w_pop) begin
        r_bus_valid <= 1'b0;
      end

      if (w_load) begin
        r_timer <= '0;
      end else if (r_state == ST_SEND && !w_pop) begin
        r_timer <= r_timer + 1'b1;
      end

      r_err <= w_timeout;
      if (w_timeout) r_err_id <= r_bus_id;
      if (w_ack_done) r_sent_count <= r_sent_count + 1'b1;
    end
  end

  assign bus_valid  = r_bus_valid;
  assign bus_id     = r_bus_id;
  assign bus_data   = r_bus_data;
  assign err        = r_err;
  assign err_id     = r_err_id;
  assign sent_count = r_sent_count;

endmodule

// File: tb/tb_bus_downlink_tx.sv
// Testbench for bus_downlink_tx: directed vector table, hand-written corner
// sequences, and a randomized run checked against a transaction-level model.
module tb_bus_downlink_tx;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_id;
  logic [31:0] in_data;
  logic        bus_valid;
  logic [3:0]  bus_id;
  logic [31:0] bus_data;
  logic        bus_ack;
  logic [3:0]  bus_ack_id;
  logic        err;
  logic [3:0]  err_id;
  logic [7:0]  sent_count;

  always #5 clk = ~clk;

  bus_downlink_tx #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_id      (in_id),
    .in_data    (in_data),
    .bus_valid  (bus_valid),
    .bus_id     (bus_id),
    .bus_data   (bus_data),
    .bus_ack    (bus_ack),
    .bus_ack_id (bus_ack_id),
    .err        (err),
    .err_id     (err_id),
    .sent_count (sent_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- reference model (transaction level) ----------------
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
  } ent_t;

  ent_t       mq[$];      // everything accepted and not yet finished, head first
  bit         m_valid;    // a transaction is on the bus
  ent_t       m_cur;
  int         m_high;     // number of cycles the current transaction has been visible
  bit         m_err;
  logic [3:0] m_err_id;
  logic [7:0] m_sent;

  function automatic void model_reset();
    mq.delete();
    m_valid  = 1'b0;
    m_cur    = '0;
    m_high   = 0;
    m_err    = 1'b0;
    m_err_id = '0;
    m_sent   = '0;
  endfunction

  // Advance the model by one rising edge using the inputs currently driven.
  function automatic void model_step();
    bit acc;
    ent_t dummy;
    acc   = in_valid && (mq.size() < DEPTH);
    m_err = 1'b0;
    if (m_valid) begin
      if (bus_ack && bus_ack_id == m_cur.id) begin
        dummy   = mq.pop_front();
        m_sent  = m_sent + 8'd1;
        m_valid = 1'b0;
      end else if (m_high == TIMEOUT) begin
        dummy    = mq.pop_front();
        m_err    = 1'b1;
        m_err_id = m_cur.id;
        m_valid  = 1'b0;
      end else begin
        m_high++;
      end
    end else if (mq.size() > 0) begin
      m_cur   = mq[0];
      m_valid = 1'b1;
      m_high  = 1;
    end
    if (acc) mq.push_back({in_id, in_data});
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid   = 1'b0;
    in_id      = '0;
    in_data    = '0;
    bus_ack    = 1'b0;
    bus_ack_id = '0;
  endtask

  // Called at posedge+1; returns at posedge+1 with the block freshly reset.
  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    #20;
    reset = 1'b1;
    model_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          iv;
    logic [3:0]  iid;
    logic [31:0] idat;
    bit          ack;
    logic [3:0]  aid;
    bit          ev;
    logic [3:0]  eid;
    logic [31:0] edat;
    bit          erdy;
    bit          eerr;
    logic [7:0]  esent;
  } vec_t;

  vec_t tbl[10];

  int hi, errs, guard, idle, vcnt;

  initial begin
    idle_inputs();
    reset = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_bus_valid", bus_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_bus_id", bus_id, 0);
    check("rst_bus_data", bus_data, 0);
    check("rst_err", err, 0);
    check("rst_err_id", err_id, 0);
    check("rst_sent", sent_count, 0);

    // Single write with late ack, then wrong-id ack followed by right-id ack,
    // then an ack while idle.
    tbl[0] = '{1, 4'd2, 32'hDEADBEEF, 0, 4'd0, 0, 4'd0, 32'h0,        1, 0, 8'd0};
    tbl[1] = '{0, 4'd0, 32'h0,        0, 4'd0, 1, 4'd2, 32'hDEADBEEF, 1, 0, 8'd0};
    tbl[2] = '{0, 4'd0, 32'h0,        0, 4'd0, 1, 4'd2, 32'hDEADBEEF, 1, 0, 8'd0};
    tbl[3] = '{0, 4'd0, 32'h0,        0, 4'd0, 1, 4'd2, 32'hDEADBEEF, 1, 0, 8'd0};
    tbl[4] = '{0, 4'd0, 32'h0,        1, 4'd2, 0, 4'd0, 32'h0,        1, 0, 8'd1};
    tbl[5] = '{1, 4'd3, 32'h00C0FFEE, 0, 4'd0, 0, 4'd0, 32'h0,        1, 0, 8'd1};
    tbl[6] = '{0, 4'd0, 32'h0,        0, 4'd0, 1, 4'd3, 32'h00C0FFEE, 1, 0, 8'd1};
    tbl[7] = '{0, 4'd0, 32'h0,        1, 4'd1, 1, 4'd3, 32'h00C0FFEE, 1, 0, 8'd1};
    tbl[8] = '{0, 4'd0, 32'h0,        1, 4'd3, 0, 4'd0, 32'h0,        1, 0, 8'd2};
    tbl[9] = '{0, 4'd0, 32'h0,        1, 4'd3, 0, 4'd0, 32'h0,        1, 0, 8'd2};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      in_valid   = tbl[i].iv;
      in_id      = tbl[i].iid;
      in_data    = tbl[i].idat;
      bus_ack    = tbl[i].ack;
      bus_ack_id = tbl[i].aid;
      tick();
      $display("vec %0d: bus_valid=%0d bus_id=%0d bus_data=%08h sent=%0d err=%0d",
               i, bus_valid, bus_id, bus_data, sent_count, err);
      check($sformatf("vec%0d_valid", i), bus_valid, tbl[i].ev);
      if (tbl[i].ev) begin
        check($sformatf("vec%0d_id", i), bus_id, tbl[i].eid);
        check($sformatf("vec%0d_data", i), bus_data, tbl[i].edat);
      end
      check($sformatf("vec%0d_ready", i), in_ready, tbl[i].erdy);
      check($sformatf("vec%0d_err", i), err, tbl[i].eerr);
      check($sformatf("vec%0d_sent", i), sent_count, tbl[i].esent);
    end
    idle_inputs();

    // Timeout: never ack.
    do_reset();
    in_valid = 1'b1; in_id = 4'd5; in_data = 32'h5555_0005;
    tick();
    idle_inputs();
    hi = 0; errs = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (bus_valid) hi++;
      if (err) begin
        errs++;
        check("to_err_id", err_id, 4'd5);
        check("to_valid_at_err", bus_valid, 0);
      end
    end
    $display("timeout txn: valid_cycles=%0d err_pulses=%0d err_id=%0d", hi, errs, err_id);
    check("to_valid_cycles", hi, TIMEOUT);
    check("to_err_pulses", errs, 1);
    check("to_sent", sent_count, 0);

    // Ack arriving on the timeout edge counts as an ack.
    do_reset();
    in_valid = 1'b1; in_id = 4'd7; in_data = 32'h7777_0007;
    tick();
    idle_inputs();
    guard = 0;
    while (!bus_valid && guard < 10) begin tick(); guard++; end
    check("ate_first_valid", bus_valid, 1);
    vcnt = 0;
    for (int c = 0; c < TIMEOUT - 1; c++) begin
      tick();
      if (bus_valid) vcnt++;
    end
    check("ate_still_valid", vcnt, TIMEOUT - 1);
    bus_ack = 1'b1; bus_ack_id = 4'd7;
    tick();
    idle_inputs();
    $display("ack-at-timeout txn: valid=%0d err=%0d sent=%0d", bus_valid, err, sent_count);
    check("ate_valid", bus_valid, 0);
    check("ate_err", err, 0);
    check("ate_sent", sent_count, 1);
    tick();
    check("ate_err_after", err, 0);

    // Full queue: five back-to-back pushes, only four accepted.
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      in_valid = 1'b1; in_id = 4'(k); in_data = 32'(k) * 32'h0101_0101;
      tick();
      if (k < 4) check($sformatf("full_ready_%0d", k), in_ready, 1);
      else       check($sformatf("full_ready_%0d", k), in_ready, 0);
    end
    idle_inputs();
    for (int k = 1; k <= 4; k++) begin
      idle = 0; guard = 0;
      while (!bus_valid && guard < 20) begin tick(); idle++; guard++; end
      $display("full txn %0d: bus_id=%0d bus_data=%08h idle_before=%0d", k, bus_id, bus_data, idle);
      check($sformatf("full_valid_%0d", k), bus_valid, 1);
      check($sformatf("full_id_%0d", k), bus_id, 4'(k));
      check($sformatf("full_data_%0d", k), bus_data, 32'(k) * 32'h0101_0101);
      if (k > 1) check($sformatf("full_gap_%0d", k), idle >= 1, 1);
      bus_ack = 1'b1; bus_ack_id = 4'(k);
      tick();
      idle_inputs();
      check($sformatf("full_ready_after_pop_%0d", k), in_ready, 1);
    end
    vcnt = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (bus_valid) vcnt++;
    end
    check("full_fifth_dropped", vcnt, 0);
    check("full_sent", sent_count, 4);

    // Reset in the middle of a transaction with three entries queued.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_id = 4'(9 + k); in_data = 32'hA000_0000 + 32'(k);
      tick();
    end
    idle_inputs();
    check("mid_valid_before", bus_valid, 1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_valid_async", bus_valid, 0);
    check("mid_ready_async", in_ready, 0);
    check("mid_sent_async", sent_count, 0);
    #10;
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    vcnt = 0; errs = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (bus_valid) vcnt++;
      if (err) errs++;
    end
    check("mid_no_valid", vcnt, 0);
    check("mid_no_err", errs, 0);
    check("mid_sent", sent_count, 0);
    in_valid = 1'b1; in_id = 4'd12; in_data = 32'h0000_0C0C;
    tick();
    idle_inputs();
    tick();
    $display("post-reset txn: bus_valid=%0d bus_id=%0d", bus_valid, bus_id);
    check("mid_new_valid", bus_valid, 1);
    check("mid_new_id", bus_id, 4'd12);

    // Randomized run against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      in_valid = ($urandom_range(0, 99) < 55);
      in_id    = 4'($urandom);
      in_data  = $urandom;
      bus_ack  = ($urandom_range(0, 99) < 18);
      if (m_valid && $urandom_range(0, 3) != 0) bus_ack_id = m_cur.id;
      else bus_ack_id = 4'($urandom);
      tick();
      check($sformatf("rand%0d_ctl", c),
            {bus_valid, in_ready, err, err_id, sent_count},
            {m_valid, (mq.size() < DEPTH), m_err, m_err_id, m_sent});
      if (m_valid) check($sformatf("rand%0d_payload", c), {bus_id, bus_data}, {m_cur.id, m_cur.data});
    end
    idle_inputs();
    $display("random run: sent=%0d", sent_count);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bus_downlink_tx.md
BUS_DOWNLINK_TX -- requirements
Module: bus_downlink_tx

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, the number of queued entries (power of two, 2..16).
REQ-002 The block SHALL have parameter TIMEOUT, default 8, the maximum bus_valid cycles allowed per transaction without a matching ack (1..255).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit, host offers an entry.
REQ-006 The block SHALL have port in_ready, output, 1 bit, queue can accept an entry.
REQ-007 The block SHALL have port in_id, input, 4 bits, destination device id.
REQ-008 The block SHALL have port in_data, input, 32 bits, payload.
REQ-009 The block SHALL have port bus_valid, output, 1 bit, transaction on the downlink bus.
REQ-010 The block SHALL have port bus_id, output, 4 bits, addressed device.
REQ-011 The block SHALL have port bus_data, output, 32 bits, payload to device.
REQ-012 The block SHALL have port bus_ack, input, 1 bit, device acknowledge, shared wire.
REQ-013 The block SHALL have port bus_ack_id, input, 4 bits, id of the acknowledging device.
REQ-014 The block SHALL have port err, output, 1 bit, one-cycle pulse on timeout.
REQ-015 The block SHALL have port err_id, output, 4 bits, id of the timed-out entry, held until the next timeout.
REQ-016 The block SHALL have port sent_count, output, 8 bits, count of acknowledged transactions.

Function
REQ-017 The queue SHALL be a FIFO of DEPTH {id,data} entries; push on a rising edge with in_valid && in_ready.
REQ-018 in_ready SHALL be 1 iff the queue is not full and reset is deasserted, derived from registered occupancy only.
REQ-019 The FSM SHALL have exactly two states: IDLE and SEND.
REQ-020 IDLE -> SEND SHALL occur on the first edge at which the queue is non-empty; the queue head is loaded into bus_id/bus_data and bus_valid=1 on the same edge.
REQ-021 An entry pushed into an empty queue at edge N SHALL appear with bus_valid=1 after edge N+1.
REQ-022 bus_id and bus_data SHALL remain stable while bus_valid=1.
REQ-023 A matching ack (bus_ack=1 && bus_ack_id==bus_id, sampled in SEND) SHALL pop the head, increment sent_count (wrapping 255->0), clear bus_valid and return to IDLE on that edge.
REQ-024 bus_ack with non-matching bus_ack_id, or any bus_ack in IDLE, SHALL be ignored.
REQ-025 A timer SHALL clear on entry to SEND and increment on each SEND edge without a matching ack; at the edge where the timer equals TIMEOUT-1 without a matching ack, the head SHALL be popped, err pulsed for one cycle, err_id loaded with bus_id, bus_valid cleared, and the FSM SHALL return to IDLE; sent_count SHALL be unchanged.
REQ-026 Matching ack and timeout at the same edge SHALL be treated as an ack (no err).
REQ-027 bus_valid SHALL be 0 for at least one cycle between consecutive transactions.
REQ-028 Simultaneous push and pop SHALL both take effect; occupancy unchanged.
REQ-029 When full, in_valid SHALL be ignored and no entry overwritten; the pop that frees a slot SHALL raise in_ready on the following cycle.

Reset
REQ-030 While reset=0, asynchronously: queue empty, FSM IDLE, timer 0, bus_valid=0, bus_id=0, bus_data=0, err=0, err_id=0, sent_count=0, in_ready=0.
REQ-031 Reset asserted mid-transaction SHALL abort it and discard all queued entries; no err pulse SHALL result.

Verification
REQ-032 Single write: push {id=2,data=0xDEADBEEF} at edge N -> bus_valid=1, bus_id=2, bus_data=0xDEADBEEF after edge N+1; ack id 2 three cycles later -> bus_valid=0, sent_count=1.
REQ-033 Timeout: push id=5, never ack -> bus_valid high exactly 8 cycles, err pulse 1 cycle, err_id=5, sent_count=0.
REQ-034 Wrong-id ack: push id=3, ack with id 1 then id 3 -> first ignored, second completes, no err.
REQ-035 Full queue: push 5 entries back-to-back with no ack -> in_ready=0 after 4th push, 5th not accepted; entries emitted in order 1..4 as each is acked, each separated by >=1 idle cycle.
REQ-036 Ack at the timeout edge (8th valid cycle) -> sent_count increments, err stays 0.
REQ-037 Reset low during SEND with 3 entries queued -> bus_valid=0 immediately, after release no bus_valid until a new push, sent_count=0.
